// File: rtl/mandel_view_ctrl.sv
// View/navigation controller for the Mandelbrot renderer: turns button pulses into x/y/step/
// iteration parameters plus render start pulses. Define MANDEL_VIEW_HIST_EN for undo history.
module mandel_view_ctrl #(
  parameter int                         FP_WIDTH  = 20,
  parameter int                         FB_WIDTH  = 320,
  parameter int                         FB_HEIGHT = 180,
  parameter logic signed [FP_WIDTH-1:0] X_START   = 20'hC8000,
  parameter logic signed [FP_WIDTH-1:0] Y_START   = 20'hE8000,
  parameter logic signed [FP_WIDTH-1:0] STEP_MAX  = 20'h00400,
  parameter int                         PAN_SHIFT = 4,
  parameter int                         ITERW     = 8,
  parameter int                         ITER_DEF  = 128,
  parameter int                         ITER_MIN  = 32,
  parameter int                         ITER_LIM  = 255,
  parameter int                         ITER_STEP = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sig_mode,
  input  logic                       sig_up,
  input  logic                       sig_dn,
  input  logic                       sig_home,
  input  logic                       sig_undo,
  input  logic                       render_busy,
  output logic signed [FP_WIDTH-1:0] x_start,
  output logic signed [FP_WIDTH-1:0] y_start,
  output logic signed [FP_WIDTH-1:0] step,
  output logic [ITERW-1:0]           iter_max,
  output logic                       start,
  output logic [1:0]                 mode,
  output logic                       rejected
);

  typedef enum logic [1:0] {StIdle, StCalc, StCommit, StKick} state_e;
  typedef enum logic [1:0] {CmdUp, CmdDn, CmdHome, CmdUndo} cmd_e;

  localparam logic [1:0] ModeHoriz = 2'd0;
  localparam logic [1:0] ModeVert  = 2'd1;
  localparam logic [1:0] ModeZoom  = 2'd2;
  localparam logic [1:0] ModeIter  = 2'd3;

  // Zoom out keeps the centre by moving half a screen; zoom in by a quarter (at the old step).
  localparam logic signed [FP_WIDTH-1:0] ZoomOutX = FP_WIDTH'(FB_WIDTH / 2);
  localparam logic signed [FP_WIDTH-1:0] ZoomOutY = FP_WIDTH'(FB_HEIGHT / 2);
  localparam logic signed [FP_WIDTH-1:0] ZoomInX  = FP_WIDTH'(FB_WIDTH / 4);
  localparam logic signed [FP_WIDTH-1:0] ZoomInY  = FP_WIDTH'(FB_HEIGHT / 4);

  state_e                      state_q, state_d;
  cmd_e                        cmd_q, cmd_d;
  logic [1:0]                  cmd_mode_q, cmd_mode_d;
  logic [1:0]                  mode_q, mode_d;
  logic signed [FP_WIDTH-1:0]  x_q, x_d, y_q, y_d, step_q, step_d;
  logic [ITERW-1:0]            iter_q, iter_d;
  logic signed [FP_WIDTH-1:0]  xc_q, xc_d, yc_q, yc_d, sc_q, sc_d;
  logic [ITERW-1:0]            ic_q, ic_d;
  logic                        start_q, start_d;
  logic                        rejected_q, rejected_d;

  logic signed [FP_WIDTH-1:0]  cand_x, cand_y, cand_s, pan;
  logic [ITERW-1:0]            cand_i, iter_up, iter_dn;
  logic                        cand_ok, dir_up, undo_req;
  int                          iter_inc, iter_dec;

`ifdef MANDEL_VIEW_HIST_EN
  localparam int HistDepth = 4;

  typedef struct packed {
    logic signed [FP_WIDTH-1:0] x;
    logic signed [FP_WIDTH-1:0] y;
    logic signed [FP_WIDTH-1:0] s;
    logic [ITERW-1:0]           it;
  } view_t;

  // Entry 0 is the top of the stack; pushes shift older views towards the end.
  view_t      hist_q [HistDepth];
  view_t      hist_d [HistDepth];
  logic [2:0] hist_cnt_q, hist_cnt_d;
  logic       hist_push, hist_pop;

  assign undo_req = sig_undo;
`else
  logic unused_sig_undo;

  assign unused_sig_undo = sig_undo;
  assign undo_req        = 1'b0;
`endif

  assign pan      = step_q <<< PAN_SHIFT;
  assign dir_up   = (cmd_q == CmdUp);
  assign iter_inc = int'(iter_q) + ITER_STEP;
  assign iter_dec = int'(iter_q) - ITER_STEP;
  assign iter_up  = (iter_inc > ITER_LIM) ? ITERW'(ITER_LIM) : ITERW'(iter_inc);
  assign iter_dn  = (iter_dec < ITER_MIN) ? ITERW'(ITER_MIN) : ITERW'(iter_dec);

  // Candidate view from the command latched at acceptance and the current view.
  always_comb begin
    cand_x = x_q;
    cand_y = y_q;
    cand_s = step_q;
    cand_i = iter_q;
    case (cmd_q)
      CmdHome: begin
        cand_x = X_START;
        cand_y = Y_START;
        cand_s = STEP_MAX;
        cand_i = ITERW'(ITER_DEF);
      end
`ifdef MANDEL_VIEW_HIST_EN
      CmdUndo: begin
        cand_x = hist_q[0].x;
        cand_y = hist_q[0].y;
        cand_s = hist_q[0].s;
        cand_i = hist_q[0].it;
      end
`endif
      default: begin
        case (cmd_mode_q)
          ModeHoriz: cand_x = dir_up ? x_q - pan : x_q + pan;
          ModeVert:  cand_y = dir_up ? y_q - pan : y_q + pan;
          ModeZoom: begin
            if (dir_up) begin
              cand_x = x_q - step_q * ZoomOutX;
              cand_y = y_q - step_q * ZoomOutY;
              cand_s = step_q <<< 1;
            end else begin
              cand_x = x_q + step_q * ZoomInX;
              cand_y = y_q + step_q * ZoomInY;
              cand_s = step_q >>> 1;
            end
          end
          default:   cand_i = dir_up ? iter_up : iter_dn;
        endcase
      end
    endcase
  end

  always_comb begin
    cand_ok = 1'b1;
    if (cmd_q == CmdUndo) begin
`ifdef MANDEL_VIEW_HIST_EN
      cand_ok = (hist_cnt_q != 3'd0);
`else
      cand_ok = 1'b0;
`endif
    end else if (cmd_q != CmdHome) begin
      // An ITER candidate equal to the current limit means we are already saturated.
      cand_ok = (sc_q != '0) && (sc_q <= STEP_MAX) &&
                !((cmd_mode_q == ModeIter) && (ic_q == iter_q));
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cmd_mode_d = cmd_mode_q;
    mode_d     = mode_q + {1'b0, sig_mode};
    x_d        = x_q;
    y_d        = y_q;
    step_d     = step_q;
    iter_d     = iter_q;
    xc_d       = xc_q;
    yc_d       = yc_q;
    sc_d       = sc_q;
    ic_d       = ic_q;
    start_d    = 1'b0;
    rejected_d = 1'b0;
`ifdef MANDEL_VIEW_HIST_EN
    hist_push  = 1'b0;
    hist_pop   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (!render_busy && (undo_req || sig_home || sig_up || sig_dn)) begin
          state_d    = StCalc;
          cmd_mode_d = mode_q;
          if (undo_req)      cmd_d = CmdUndo;
          else if (sig_home) cmd_d = CmdHome;
          else if (sig_up)   cmd_d = CmdUp;
          else               cmd_d = CmdDn;
        end
      end
      StCalc: begin
        xc_d    = cand_x;
        yc_d    = cand_y;
        sc_d    = cand_s;
        ic_d    = cand_i;
        state_d = StCommit;
      end
      StCommit: begin
        if (cand_ok) begin
          x_d     = xc_q;
          y_d     = yc_q;
          step_d  = sc_q;
          iter_d  = ic_q;
          state_d = StKick;
`ifdef MANDEL_VIEW_HIST_EN
          hist_push = (cmd_q != CmdUndo);
          hist_pop  = (cmd_q == CmdUndo);
`endif
        end else begin
          rejected_d = 1'b1;
          state_d    = StIdle;
        end
      end
      default: begin
        if (!render_busy) begin
          start_d = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

`ifdef MANDEL_VIEW_HIST_EN
  always_comb begin
    hist_d     = hist_q;
    hist_cnt_d = hist_cnt_q;
    if (hist_push) begin
      hist_d[0] = '{x: x_q, y: y_q, s: step_q, it: iter_q};
      for (int i = 1; i < HistDepth; i++) hist_d[i] = hist_q[i-1];
      if (hist_cnt_q != 3'(HistDepth)) hist_cnt_d = hist_cnt_q + 3'd1;
    end else if (hist_pop) begin
      for (int i = 0; i < HistDepth - 1; i++) hist_d[i] = hist_q[i+1];
      hist_d[HistDepth-1] = '0;
      hist_cnt_d          = hist_cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HistDepth; i++) hist_q[i] <= '0;
      hist_cnt_q <= 3'd0;
    end else begin
      hist_q     <= hist_d;
      hist_cnt_q <= hist_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StKick;
      cmd_q      <= CmdUp;
      cmd_mode_q <= ModeHoriz;
      mode_q     <= ModeHoriz;
      x_q        <= X_START;
      y_q        <= Y_START;
      step_q     <= STEP_MAX;
      iter_q     <= ITERW'(ITER_DEF);
      xc_q       <= X_START;
      yc_q       <= Y_START;
      sc_q       <= STEP_MAX;
      ic_q       <= ITERW'(ITER_DEF);
      start_q    <= 1'b0;
      rejected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cmd_mode_q <= cmd_mode_d;
      mode_q     <= mode_d;
      x_q        <= x_d;
      y_q        <= y_d;
      step_q     <= step_d;
      iter_q     <= iter_d;
      xc_q       <= xc_d;
      yc_q       <= yc_d;
      sc_q       <= sc_d;
      ic_q       <= ic_d;
      start_q    <= start_d;
      rejected_q <= rejected_d;
    end
  end

  assign x_start  = x_q;
  assign y_start  = y_q;
  assign step     = step_q;
  assign iter_max = iter_q;
  assign start    = start_q;
  assign mode     = mode_q;
  assign rejected = rejected_q;

endmodule

// File: tb/tb_mandel_view_ctrl.sv
// Bench for mandel_view_ctrl: directed vector table, hand-written corner sequences and
// random commands checked against an arithmetic view model.
`timescale 1ns/1ps
module tb_mandel_view_ctrl;

  localparam int CMD_UP = 0, CMD_DN = 1, CMD_HOME = 2, CMD_UNDO = 3;
  localparam logic [63:0] M20 = 64'hFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_mode = 1'b0, sig_up = 1'b0, sig_dn = 1'b0, sig_home = 1'b0, sig_undo = 1'b0;
  logic        render_busy = 1'b0;
  logic [19:0] x_start, y_start, step;
  logic [7:0]  iter_max;
  logic        start, rejected;
  logic [1:0]  mode;

  int checks = 0;
  int errors = 0;

  mandel_view_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .sig_mode    (sig_mode),
    .sig_up      (sig_up),
    .sig_dn      (sig_dn),
    .sig_home    (sig_home),
    .sig_undo    (sig_undo),
    .render_busy (render_busy),
    .x_start     (x_start),
    .y_start     (y_start),
    .step        (step),
    .iter_max    (iter_max),
    .start       (start),
    .mode        (mode),
    .rejected    (rejected)
  );

  always #5 clk = ~clk;

  // Behavioural view model: coordinates kept as signed integers wrapped to 20 bits.
  typedef struct { longint x; longint y; longint s; int it; } view_t;
  longint mx, my, ms;
  int     mi, mmode;
  view_t  hist[$];
  longint X0, Y0, S0;

  typedef struct {
    int nmode; int cmd; bit ok;
    logic [19:0] x; logic [19:0] y; logic [19:0] s; logic [7:0] it;
  } vec_t;
  vec_t tbl[$];

  function automatic longint wrap(input longint v);
    longint r = v & 64'hFFFFF;
    if (r >= 64'sh80000) r = r - 64'sh100000;
    return r;
  endfunction

  function automatic void add(input int nm, input int c, input bit ok, input logic [19:0] x,
                              input logic [19:0] y, input logic [19:0] s, input logic [7:0] it);
    vec_t v;
    v.nmode = nm; v.cmd = c; v.ok = ok; v.x = x; v.y = y; v.s = s; v.it = it;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    mx = X0; my = Y0; ms = S0; mi = 128; mmode = 0;
    hist.delete();
  endtask

  task automatic model_cmd(input int cmd, output bit ok);
    longint cx, cy, cs;
    int     ci;
    bit     up;
    view_t  v;
    cx = mx; cy = my; cs = ms; ci = mi; up = (cmd == CMD_UP);
    ok = 1'b1;
    if (cmd == CMD_HOME) begin
      cx = X0; cy = Y0; cs = S0; ci = 128;
    end else if (cmd == CMD_UNDO) begin
      if (hist.size() == 0) ok = 1'b0;
      else begin
        v = hist[hist.size()-1];
        cx = v.x; cy = v.y; cs = v.s; ci = v.it;
      end
    end else begin
      case (mmode)
        0: cx = wrap(up ? mx - ms * (2 ** 4) : mx + ms * (2 ** 4));
        1: cy = wrap(up ? my - ms * (2 ** 4) : my + ms * (2 ** 4));
        2: if (up) begin
             cx = wrap(mx - ms * 160); cy = wrap(my - ms * 90); cs = wrap(ms * 2);
           end else begin
             cx = wrap(mx + ms * 80); cy = wrap(my + ms * 45); cs = ms >>> 1;
           end
        default: ci = up ? ((mi + 32 > 255) ? 255 : mi + 32) : ((mi - 32 < 32) ? 32 : mi - 32);
      endcase
      ok = (cs != 0) && (cs <= S0) && !(mmode == 3 && ci == mi);
    end
    if (ok) begin
      if (cmd == CMD_UNDO) void'(hist.pop_back());
      else begin
        v.x = mx; v.y = my; v.s = ms; v.it = mi;
        hist.push_back(v);
        if (hist.size() > 4) void'(hist.pop_front());
      end
      mx = cx; my = cy; ms = cs; mi = ci;
    end
  endtask

  task automatic mode_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      sig_mode = 1'b1;
      tick;
      sig_mode = 1'b0;
      mmode = (mmode + 1) % 4;
      chk("mode_step", 64'(mode), 64'(mmode));
    end
  endtask

  task automatic exec_cmd(input int cmd, input bit wm, input bit ok, input logic [63:0] ex,
                          input logic [63:0] ey, input logic [63:0] es, input logic [63:0] ei,
                          input string tag);
    sig_up = (cmd == CMD_UP); sig_dn = (cmd == CMD_DN);
    sig_home = (cmd == CMD_HOME); sig_undo = (cmd == CMD_UNDO); sig_mode = wm;
    tick;
    sig_up = 0; sig_dn = 0; sig_home = 0; sig_undo = 0; sig_mode = 0;
    if (wm) mmode = (mmode + 1) % 4;
    chk({tag, "_mode"}, 64'(mode), 64'(mmode));
    chk({tag, "_e0_start"}, 64'(start), 64'd0);
    tick;
    chk({tag, "_e1_rej"}, 64'(rejected), 64'd0);
    tick;
    chk({tag, "_x"}, 64'(x_start), ex);
    chk({tag, "_y"}, 64'(y_start), ey);
    chk({tag, "_step"}, 64'(step), es);
    chk({tag, "_iter"}, 64'(iter_max), ei);
    chk({tag, "_rej"}, 64'(rejected), 64'(!ok));
    chk({tag, "_e2_start"}, 64'(start), 64'd0);
    tick;
    chk({tag, "_start"}, 64'(start), 64'(ok));
    chk({tag, "_rej_end"}, 64'(rejected), 64'd0);
    if (ok) begin
      tick;
      chk({tag, "_start_end"}, 64'(start), 64'd0);
    end
  endtask

  task automatic model_exec(input int cmd, input bit wm, input string tag);
    bit ok;
    model_cmd(cmd, ok);
    exec_cmd(cmd, wm, ok, mx & M20, my & M20, ms & M20, 64'(mi), tag);
  endtask

  task automatic do_reset;
    rst = 1'b1; render_busy = 1'b0;
    sig_up = 0; sig_dn = 0; sig_home = 0; sig_undo = 0; sig_mode = 0;
    tick;
    tick;
    model_reset();
    chk("rst_x", 64'(x_start), 64'hC8000);
    chk("rst_y", 64'(y_start), 64'hE8000);
    chk("rst_step", 64'(step), 64'h00400);
    chk("rst_iter", 64'(iter_max), 64'd128);
    chk("rst_mode", 64'(mode), 64'd0);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_rej", 64'(rejected), 64'd0);
    rst = 1'b0;
    tick;
    chk("kick_start", 64'(start), 64'd1);
    tick;
    chk("kick_start_end", 64'(start), 64'd0);
  endtask

  initial begin
    bit ok;
    X0 = wrap(64'hC8000); Y0 = wrap(64'hE8000); S0 = 64'h400;

    add(0, CMD_DN,   1, 20'hCC000, 20'hE8000, 20'h00400, 8'd128);
    add(0, CMD_HOME, 1, 20'hC8000, 20'hE8000, 20'h00400, 8'd128);
    add(2, CMD_DN,   1, 20'hDC000, 20'hF3400, 20'h00200, 8'd128);
    add(0, CMD_UP,   1, 20'hC8000, 20'hE8000, 20'h00400, 8'd128);
    add(0, CMD_UP,   0, 20'hC8000, 20'hE8000, 20'h00400, 8'd128);
    // Rows below follow ten zoom-ins down to step 1.
    add(0, CMD_DN,   0, 20'hEFF60, 20'hFE7A6, 20'h00001, 8'd128);
    add(0, CMD_HOME, 1, 20'hC8000, 20'hE8000, 20'h00400, 8'd128);
    add(1, CMD_UP,   1, 20'hC8000, 20'hE8000, 20'h00400, 8'd160);
    add(0, CMD_UP,   1, 20'hC8000, 20'hE8000, 20'h00400, 8'd192);
    add(0, CMD_UP,   1, 20'hC8000, 20'hE8000, 20'h00400, 8'd224);
    add(0, CMD_UP,   1, 20'hC8000, 20'hE8000, 20'h00400, 8'd255);
    add(0, CMD_UP,   0, 20'hC8000, 20'hE8000, 20'h00400, 8'd255);
    add(0, CMD_DN,   1, 20'hC8000, 20'hE8000, 20'h00400, 8'd223);
    add(0, CMD_DN,   1, 20'hC8000, 20'hE8000, 20'h00400, 8'd191);
    add(0, CMD_DN,   1, 20'hC8000, 20'hE8000, 20'h00400, 8'd159);
    add(0, CMD_DN,   1, 20'hC8000, 20'hE8000, 20'h00400, 8'd127);
    add(0, CMD_DN,   1, 20'hC8000, 20'hE8000, 20'h00400, 8'd95);
    add(0, CMD_DN,   1, 20'hC8000, 20'hE8000, 20'h00400, 8'd63);
    add(0, CMD_DN,   1, 20'hC8000, 20'hE8000, 20'h00400, 8'd32);
    add(0, CMD_DN,   0, 20'hC8000, 20'hE8000, 20'h00400, 8'd32);
    add(1, CMD_UP,   1, 20'hC4000, 20'hE8000, 20'h00400, 8'd32);

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 5) begin
        for (int k = 0; k < 10; k++) model_exec(CMD_DN, 1'b0, "zoom_in");
        chk("zoom_min_step", 64'(step), 64'd1);
      end
      mode_pulse(tbl[i].nmode);
      model_cmd(tbl[i].cmd, ok);
      exec_cmd(tbl[i].cmd, 1'b0, tbl[i].ok, 64'(tbl[i].x), 64'(tbl[i].y), 64'(tbl[i].s),
               64'(tbl[i].it), $sformatf("vec%0d", i));
    end

    // Commands are dropped while busy, but mode still advances.
    render_busy = 1'b1;
    sig_dn = 1'b1;
    tick;
    sig_dn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("busy_drop_start", 64'(start), 64'd0);
      chk("busy_drop_rej", 64'(rejected), 64'd0);
    end
    chk("busy_drop_x", 64'(x_start), mx & M20);
    mode_pulse(1);
    mode_pulse(3);
    render_busy = 1'b0;

    // Start is held off until the engine goes idle.
    model_cmd(CMD_DN, ok);
    sig_dn = 1'b1;
    tick;
    sig_dn = 1'b0;
    tick;
    tick;
    chk("kick_hold_x", 64'(x_start), mx & M20);
    render_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("kick_hold_start", 64'(start), 64'd0);
    end
    render_busy = 1'b0;
    tick;
    chk("kick_release_start", 64'(start), 64'd1);
    tick;
    chk("kick_release_end", 64'(start), 64'd0);

    // sig_mode coinciding with a move: the move uses the old mode.
    model_exec(CMD_DN, 1'b1, "mode_coincide");
    chk("mode_coincide_y", 64'(y_start), 64'hE8000);

`ifndef MANDEL_VIEW_HIST_EN
    sig_undo = 1'b1;
    tick;
    sig_undo = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("undo_ignored_start", 64'(start), 64'd0);
      chk("undo_ignored_rej", 64'(rejected), 64'd0);
    end
`else
    do_reset();
    for (int k = 0; k < 5; k++) model_exec(CMD_DN, 1'b0, "hist_pan");
    chk("hist_pan_x", 64'(x_start), 64'hDC000);
    for (int k = 0; k < 5; k++) begin
      model_exec(CMD_UNDO, 1'b0, "hist_undo");
      if (k == 3) chk("hist_undo4_x", 64'(x_start), 64'hCC000);
    end
    chk("hist_undo5_x", 64'(x_start), 64'hCC000);
    model_exec(CMD_DN, 1'b0, "hist_pan2");
    model_exec(CMD_HOME, 1'b0, "hist_home");
    model_exec(CMD_UNDO, 1'b0, "hist_undo_home");
    chk("hist_undo_home_x", 64'(x_start), 64'hD0000);
`endif

    for (int n = 0; n < 60; n++) begin
      int c;
`ifdef MANDEL_VIEW_HIST_EN
      c = int'($urandom_range(0, 3));
`else
      c = int'($urandom_range(0, 2));
`endif
      mode_pulse(int'($urandom_range(0, 3)));
      model_exec(c, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    // Reset while a candidate is in flight discards it.
    sig_up = 1'b1;
    tick;
    sig_up = 1'b0;
    do_reset();
    tick;
    tick;
    chk("midrst_x", 64'(x_start), 64'hC8000);
    chk("midrst_rej", 64'(rejected), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
